// File: rtl/alu_nibble_sequencer.sv
// Runs one 4*NIBBLES-bit add/sub/inc/dec through a shared 4-bit datapath, one nibble per step, LSB nibble first.
// Optional flag outputs (flag_z, flag_n) are enabled by defining ALU_SEQ_FLAGS_EN.
module alu_nibble_sequencer #(
    parameter int NIBBLES       = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [4*NIBBLES-1:0]   opa,
    input  logic [4*NIBBLES-1:0]   opb,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout_out,
`ifdef ALU_SEQ_FLAGS_EN
    output logic                   flag_z,
    output logic                   flag_n,
`endif
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [1:0]             alu_s,
    output logic                   alu_cin,
    input  logic [3:0]             alu_d,
    input  logic                   alu_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0]       shadow_q, shadow_d, result_q, result_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_next;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d, done_q, done_d, cout_q, cout_d;
    logic [3:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [1:0]         alu_s_q, alu_s_d;
    logic               alu_cin_q, alu_cin_d;
`ifdef ALU_SEQ_FLAGS_EN
    logic               flag_z_q, flag_z_d, flag_n_q, flag_n_d;
`endif

    function automatic logic [3:0] nib_of(input logic [W-1:0] v, input logic [IDX_W-1:0] k);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k == IDX_W'(i)) n = v[i*4 +: 4];
        end
        return n;
    endfunction

    assign idx_next = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        shadow_d  = shadow_q;
        result_d  = result_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cout_d    = cout_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_s_d   = alu_s_q;
        alu_cin_d = alu_cin_q;
`ifdef ALU_SEQ_FLAGS_EN
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    opa_d     = opa;
                    opb_d     = opb;
                    idx_d     = '0;
                    cnt_d     = '0;
                    carry_d   = op[0];
                    busy_d    = 1'b1;
                    alu_a_d   = opa[3:0];
                    alu_b_d   = opb[3:0];
                    alu_s_d   = op[2:1];
                    alu_cin_d = op[0];
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) shadow_d[i*4 +: 4] = alu_d;
                end
                carry_d = alu_cout;
                // Only the final capture publishes; intermediate nibbles stay in the shadow.
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    result_d = shadow_d;
                    cout_d   = alu_cout;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                    flag_z_d = (shadow_d == '0);
                    flag_n_d = shadow_d[W-1];
`endif
                    state_d  = DONE;
                end else begin
                    idx_d     = idx_next;
                    cnt_d     = '0;
                    alu_a_d   = nib_of(opa_q, idx_next);
                    alu_b_d   = nib_of(opb_q, idx_next);
                    alu_cin_d = carry_d;
                    state_d   = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            shadow_q  <= '0;
            result_q  <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cout_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_s_q   <= '0;
            alu_cin_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            shadow_q  <= shadow_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cout_q    <= cout_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_s_q   <= alu_s_d;
            alu_cin_q <= alu_cin_d;
`ifdef ALU_SEQ_FLAGS_EN
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout_out = cout_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_s    = alu_s_q;
    assign alu_cin  = alu_cin_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign flag_z   = flag_z_q;
    assign flag_n   = flag_n_q;
`endif

endmodule
